alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-side issue register feeding the ALU. It accepts decoded LEGv8 instructions and register-file operands from decode over a valid/ready handshake. It translates the opcode into the 4-bit ALU control code and selects the two ALU operands. It presents them, registered, to the ALU through a two-entry skid buffer with stall and flush support.

## Interface
Parameters:
- `WORD`: default from `definitions.vh` (64). Operand width.
- FIFO-free; depth fixed at 2 (main register + skid register).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  decode presents an instruction.
- `in_ready`  out  1  stage can accept; registered.
- `in_opcode`  in  11  instruction[31:21].
- `in_rn`, `in_rm`, `in_rt`  in  5 each  source register indices.
- `in_rn_data`, `in_rm_data`, `in_rt_data`  in  `WORD` each  register-file read data.
- `in_dt_addr`  in  9  D-type address immediate, instruction[20:12].
- `out_valid`  out  1  ALU inputs valid.
- `out_ready`  in  1  execute consumes this cycle.
- `alu_control`  out  4  ALU control code.
- `data_1`, `data_2`  out  `WORD`  ALU operands.
- `illegal`  out  1  issued entry had an undecodable opcode.
- `flush`  in  1  discard all held entries.
- `fwd_valid`  in  1  forwarding source valid.
- `fwd_rd`  in  5  forwarding source destination register.
- `fwd_data`  in  `WORD`  forwarding source value.

## Operation
- Decode (priority top-down):
  - opcode `10001011000` → `alu_add`, d1=Rn, d2=Rm.
  - `11001011000` → `alu_sub`, d1=Rn, d2=Rm.
  - `10001010000` → `alu_and`, d1=Rn, d2=Rm.
  - `10101010000` → `alu_orr`, d1=Rn, d2=Rm.
  - `11111000010` (LDUR) and `11111000000` (STUR) → `alu_add`, d1=Rn, d2=sign-extend(`in_dt_addr`) to `WORD`.
  - opcode[10:3]=`10110100` (CBZ) → `alu_cbz`, d1=0, d2=Rt.
  - Anything else → `alu_and`, d1=d2=0, `illegal`=1.
- Transfer on input when `in_valid & in_ready`; on output when `out_valid & out_ready`.
- Decode and operand selection happen combinationally at acceptance; only resolved values are stored.
- Ordering is strict FIFO: the skid entry moves to main when main drains.
- Register 31 reads as zero in the operand path regardless of `in_*_data`.

## Timing
- Reset: `out_valid`=0, `alu_control`=0, `data_1`=`data_2`=0, `illegal`=0, skid empty. `in_ready`=1 from the first cycle after reset release.
- Latency: accepted in cycle N, visible on outputs in cycle N+1.
- Throughput: 1/cycle while `out_ready`=1.
- `out_ready`=0 with main full: the next accepted instruction goes to skid. `in_ready` drops the following cycle.
- Both entries full: `in_ready`=0. When main drains, skid moves to main and `in_ready` rises the next cycle.
- Simultaneous drain and accept with skid empty: the new entry goes to main with no bubble.
- `flush`: both entries invalid the next cycle, and any same-cycle input is discarded. `flush` beats accept and drain.
- Reset asserted mid-stall returns the block to the reset state regardless of `flush`/`out_ready`.
- Outputs are held stable while `out_valid & ~out_ready`.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: at acceptance, a source operand whose index equals `fwd_rd` while `fwd_valid`=1 and index≠31 takes `fwd_data` instead of register-file data. This applies to Rn, Rm and Rt independently.
- Undefined: the `fwd_*` ports remain but are ignored, and operands always come from the register file.

## Structure
- `definitions.vh` holds `WORD`, the `alu_*` control codes and new opcode constants: `op_add`, `op_sub`, `op_and`, `op_orr`, `op_ldur`, `op_stur`, `op_cbz`.
- Sub-module `alu_opdecode`: combinational opcode → {control, operand-select, illegal}.
- The skid/handshake logic stays in the top module.

## Test plan
- ADD, Rn=5, Rm=7, `out_ready`=1 → next cycle `alu_control`=`alu_add`, `data_1`=5, `data_2`=7, `out_valid`=1.
- LDUR with `in_dt_addr`=9'h1F8 (−8), Rn=0x100 → `data_2`=64'hFFFF_FFFF_FFFF_FFF8, control `alu_add`.
- Three back-to-back SUBs with `out_ready`=0 → `in_ready` falls after the second. Releasing `out_ready` yields all in order with no loss or duplication.
- CBZ with Rt=0 → `alu_control`=`alu_cbz`, `data_2`=0. Opcode `00000000000` → `illegal`=1, operands 0.
- Both entries full, assert `flush` with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the new input is dropped.
- With `ALU_ISSUE_FWD_EN`: ORR with Rn=3, `fwd_valid`=1, `fwd_rd`=3, `fwd_data`=0xAA → `data_1`=0xAA. With `fwd_rd`=31 → register-file zero is used.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared constants for the ALU issue stage: operand width, ALU control codes,
// LEGv8 opcode patterns and the operand-select encoding produced by the decoder.
package alu_issue_stage_pkg;

    localparam int WORD = 64;

    // ALU control codes (LEGv8 ALU control encoding)
    localparam logic [3:0] alu_and = 4'b0000;
    localparam logic [3:0] alu_orr = 4'b0001;
    localparam logic [3:0] alu_add = 4'b0010;
    localparam logic [3:0] alu_sub = 4'b0110;
    localparam logic [3:0] alu_cbz = 4'b0111;

    // Full 11-bit opcodes, instruction[31:21]
    localparam logic [10:0] op_add  = 11'b10001011000;
    localparam logic [10:0] op_sub  = 11'b11001011000;
    localparam logic [10:0] op_and  = 11'b10001010000;
    localparam logic [10:0] op_orr  = 11'b10101010000;
    localparam logic [10:0] op_ldur = 11'b11111000010;
    localparam logic [10:0] op_stur = 11'b11111000000;
    // CBZ is identified by its 8-bit prefix, instruction[31:24]
    localparam logic [7:0]  op_cbz  = 8'b10110100;

    // Which values feed data_1 / data_2
    typedef enum logic [1:0] {
        sel_rn_rm     = 2'd0,   // d1 = Rn, d2 = Rm
        sel_rn_imm    = 2'd1,   // d1 = Rn, d2 = sign-extended D-type address
        sel_zero_rt   = 2'd2,   // d1 = 0,  d2 = Rt
        sel_zero_zero = 2'd3    // d1 = 0,  d2 = 0
    } opsel_e;

    function automatic logic is_cbz(input logic [10:0] opcode);
        return opcode[10:3] == op_cbz;
    endfunction

endpackage

// File: rtl/alu_opdecode.sv
// Combinational opcode decoder: opcode -> ALU control, operand select, illegal.
module alu_opdecode
    import alu_issue_stage_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [3:0]  alu_control,
    output opsel_e      opsel,
    output logic        illegal
);

    // Priority decode; unknown opcodes become a harmless AND of zeros flagged illegal
    always_comb begin
        alu_control = alu_and;
        opsel       = sel_zero_zero;
        illegal     = 1'b0;
        if (opcode == op_add) begin
            alu_control = alu_add;
            opsel       = sel_rn_rm;
        end else if (opcode == op_sub) begin
            alu_control = alu_sub;
            opsel       = sel_rn_rm;
        end else if (opcode == op_and) begin
            alu_control = alu_and;
            opsel       = sel_rn_rm;
        end else if (opcode == op_orr) begin
            alu_control = alu_orr;
            opsel       = sel_rn_rm;
        end else if (opcode == op_ldur || opcode == op_stur) begin
            alu_control = alu_add;
            opsel       = sel_rn_imm;
        end else if (is_cbz(opcode)) begin
            alu_control = alu_cbz;
            opsel       = sel_zero_rt;
        end else begin
            illegal     = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue register: decodes at acceptance and holds resolved ALU inputs in a
// two-entry skid buffer (main + skid) with flush.
// Optional feature macro: ALU_ISSUE_FWD_EN enables operand forwarding from fwd_*.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int W = WORD
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [10:0]  in_opcode,
    input  logic [4:0]   in_rn,
    input  logic [4:0]   in_rm,
    input  logic [4:0]   in_rt,
    input  logic [W-1:0] in_rn_data,
    input  logic [W-1:0] in_rm_data,
    input  logic [W-1:0] in_rt_data,
    input  logic [8:0]   in_dt_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   alu_control,
    output logic [W-1:0] data_1,
    output logic [W-1:0] data_2,
    output logic         illegal,
    input  logic         flush,
    input  logic         fwd_valid,
    input  logic [4:0]   fwd_rd,
    input  logic [W-1:0] fwd_data
);

    typedef struct packed {
        logic [3:0]   ctrl;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic         ill;
    } entry_t;

    logic [3:0] dec_ctrl;
    opsel_e     dec_sel;
    logic       dec_ill;

    alu_opdecode u_dec (
        .opcode      (in_opcode),
        .alu_control (dec_ctrl),
        .opsel       (dec_sel),
        .illegal     (dec_ill)
    );

    // Source operands: index 0 = Rn, 1 = Rm, 2 = Rt
    logic [4:0]   src_idx [3];
    logic [W-1:0] src_rf  [3];
    logic [W-1:0] src_val [3];

    assign src_idx[0] = in_rn;
    assign src_idx[1] = in_rm;
    assign src_idx[2] = in_rt;
    assign src_rf[0]  = in_rn_data;
    assign src_rf[1]  = in_rm_data;
    assign src_rf[2]  = in_rt_data;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
`ifdef ALU_ISSUE_FWD_EN
            // X31 is the zero register and is never a forwarding target
            assign src_val[gi] = (src_idx[gi] == 5'd31)                  ? '0       :
                                 (fwd_valid && (fwd_rd == src_idx[gi]))  ? fwd_data :
                                                                           src_rf[gi];
`else
            assign src_val[gi] = (src_idx[gi] == 5'd31) ? '0 : src_rf[gi];
`endif
        end
    endgenerate

`ifndef ALU_ISSUE_FWD_EN
    // Forwarding ports exist in every build; without the feature they are sinks
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data};
`endif

    logic [W-1:0] dt_sext;
    assign dt_sext = {{(W-9){in_dt_addr[8]}}, in_dt_addr};

    entry_t new_entry;

    // Operand selection: only resolved values enter the buffer
    always_comb begin
        new_entry      = '0;
        new_entry.ctrl = dec_ctrl;
        new_entry.ill  = dec_ill;
        case (dec_sel)
            sel_rn_rm: begin
                new_entry.d1 = src_val[0];
                new_entry.d2 = src_val[1];
            end
            sel_rn_imm: begin
                new_entry.d1 = src_val[0];
                new_entry.d2 = dt_sext;
            end
            sel_zero_rt: begin
                new_entry.d1 = '0;
                new_entry.d2 = src_val[2];
            end
            default: begin
                new_entry.d1 = '0;
                new_entry.d2 = '0;
            end
        endcase
    end

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;

    // in_ready mirrors "skid empty", so an accept never coincides with a full skid
    assign accept = in_valid & in_ready_q;
    assign drain  = main_valid_q & out_ready;

    // Buffer next state: flush wins, then drain (with skid refill), then accept
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end else begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign alu_control = main_q.ctrl;
    assign data_1      = main_q.d1;
    assign data_2      = main_q.d2;
    assign illegal     = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed steps then random traffic,
// compared against a queue-based reference model of the issue stage.
module tb_alu_issue_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [10:0] in_opcode;
    logic [4:0]  in_rn, in_rm, in_rt;
    logic [63:0] in_rn_data, in_rm_data, in_rt_data;
    logic [8:0]  in_dt_addr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [63:0] data_1, data_2;
    logic        illegal;
    logic        flush;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;

    alu_issue_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opcode   (in_opcode),
        .in_rn       (in_rn),
        .in_rm       (in_rm),
        .in_rt       (in_rt),
        .in_rn_data  (in_rn_data),
        .in_rm_data  (in_rm_data),
        .in_rt_data  (in_rt_data),
        .in_dt_addr  (in_dt_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .data_1      (data_1),
        .data_2      (data_2),
        .illegal     (illegal),
        .flush       (flush),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  c;
        logic [63:0] d1;
        logic [63:0] d2;
        logic        ill;
    } exp_t;

    exp_t model_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value of a source register as seen by the issue stage
    function automatic logic [63:0] src(input logic [4:0] idx, input logic [63:0] rf);
        if (idx == 5'd31) return 64'd0;
`ifdef ALU_ISSUE_FWD_EN
        if (fwd_valid && fwd_rd == idx) return fwd_data;
`endif
        return rf;
    endfunction

    // Reference decode straight from the opcode table
    function automatic exp_t ref_decode();
        exp_t e;
        logic [63:0] rn_v, rm_v, rt_v;
        rn_v = src(in_rn, in_rn_data);
        rm_v = src(in_rm, in_rm_data);
        rt_v = src(in_rt, in_rt_data);
        if      (in_opcode == 11'b10001011000) e = '{4'b0010, rn_v, rm_v, 1'b0};
        else if (in_opcode == 11'b11001011000) e = '{4'b0110, rn_v, rm_v, 1'b0};
        else if (in_opcode == 11'b10001010000) e = '{4'b0000, rn_v, rm_v, 1'b0};
        else if (in_opcode == 11'b10101010000) e = '{4'b0001, rn_v, rm_v, 1'b0};
        else if (in_opcode == 11'b11111000010 || in_opcode == 11'b11111000000)
            e = '{4'b0010, rn_v, 64'($signed(in_dt_addr)), 1'b0};
        else if (in_opcode[10:3] == 8'b10110100) e = '{4'b0111, 64'd0, rt_v, 1'b0};
        else e = '{4'b0000, 64'd0, 64'd0, 1'b1};
        return e;
    endfunction

    // Advance model and DUT by one clock, then compare at the falling edge
    task automatic tick();
        bit acc, drn;
        if (!reset_n || flush) begin
            model_q.delete();
        end else begin
            drn = (model_q.size() > 0) && out_ready;
            acc = in_valid && (model_q.size() < 2);
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode());
        end
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
        chk("in_ready",  64'(in_ready),  64'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            chk("alu_control", 64'(alu_control), 64'(model_q[0].c));
            chk("data_1",      data_1,           model_q[0].d1);
            chk("data_2",      data_2,           model_q[0].d2);
            chk("illegal",     64'(illegal),     64'(model_q[0].ill));
        end
    endtask

    task automatic set_in(input logic [10:0] opc, input logic [4:0] rn, input logic [63:0] rnd,
                          input logic [4:0] rm, input logic [63:0] rmd,
                          input logic [4:0] rt, input logic [63:0] rtd, input logic [8:0] dt);
        in_valid   = 1'b1;
        in_opcode  = opc;
        in_rn = rn; in_rn_data = rnd;
        in_rm = rm; in_rm_data = rmd;
        in_rt = rt; in_rt_data = rtd;
        in_dt_addr = dt;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_ctrl"},      64'(alu_control), 64'd0);
        chk({tag, "_d1"},        data_1, 64'd0);
        chk({tag, "_d2"},        data_2, 64'd0);
        chk({tag, "_illegal"},   64'(illegal), 64'd0);
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        in_opcode = '0; in_rn = '0; in_rm = '0; in_rt = '0;
        in_rn_data = '0; in_rm_data = '0; in_rt_data = '0; in_dt_addr = '0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0;

        // Reset
        tick(); tick();
        chk_reset_state("reset");
        reset_n = 1'b1;
        tick();

        // ADD Rn=5, Rm=7
        set_in(11'b10001011000, 5'd1, 64'd5, 5'd2, 64'd7, 5'd0, 64'd0, 9'd0);
        tick();
        chk("add_ctrl", 64'(alu_control), 64'h2);
        chk("add_d1", data_1, 64'd5);
        chk("add_d2", data_2, 64'd7);
        chk("add_valid", 64'(out_valid), 64'd1);

        // LDUR with negative offset
        set_in(11'b11111000010, 5'd3, 64'h100, 5'd0, 64'd0, 5'd0, 64'd0, 9'h1F8);
        tick();
        chk("ldur_ctrl", 64'(alu_control), 64'h2);
        chk("ldur_d1", data_1, 64'h100);
        chk("ldur_d2", data_2, 64'hFFFF_FFFF_FFFF_FFF8);

        // CBZ Rt=0
        set_in(11'b10110100101, 5'd6, 64'h77, 5'd7, 64'h88, 5'd4, 64'd0, 9'd0);
        tick();
        chk("cbz_ctrl", 64'(alu_control), 64'h7);
        chk("cbz_d1", data_1, 64'd0);
        chk("cbz_d2", data_2, 64'd0);

        // Undecodable opcode
        set_in(11'b00000000000, 5'd1, 64'h55, 5'd2, 64'h66, 5'd3, 64'h77, 9'h0AB);
        tick();
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_d1", data_1, 64'd0);
        chk("ill_d2", data_2, 64'd0);

        // Drain, then three SUBs under stall
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        set_in(11'b11001011000, 5'd1, 64'h11, 5'd2, 64'h1, 5'd0, 64'd0, 9'd0);
        tick();
        chk("sub_a_ready", 64'(in_ready), 64'd1);
        set_in(11'b11001011000, 5'd1, 64'h22, 5'd2, 64'h2, 5'd0, 64'd0, 9'd0);
        tick();
        chk("sub_b_ready_fall", 64'(in_ready), 64'd0);
        set_in(11'b11001011000, 5'd1, 64'h33, 5'd2, 64'h3, 5'd0, 64'd0, 9'd0);
        tick();
        chk("sub_stall_hold_d1", data_1, 64'h11);
        out_ready = 1'b1;
        tick();
        chk("sub_order_b", data_1, 64'h22);
        chk("sub_ready_rise", 64'(in_ready), 64'd1);
        tick();
        chk("sub_order_c", data_1, 64'h33);
        in_valid = 1'b0;
        tick();
        chk("sub_empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and an input present
        out_ready = 1'b0;
        set_in(11'b10001011000, 5'd1, 64'hA1, 5'd2, 64'd1, 5'd0, 64'd0, 9'd0);
        tick();
        set_in(11'b10001011000, 5'd1, 64'hA2, 5'd2, 64'd2, 5'd0, 64'd0, 9'd0);
        tick();
        chk("full_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        chk("flush_dropped", 64'(out_valid), 64'd0);

        // Reset asserted mid-stall
        set_in(11'b10101010000, 5'd1, 64'hB1, 5'd2, 64'd1, 5'd0, 64'd0, 9'd0);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        chk_reset_state("midreset");
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // Forwarding
        fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 64'hAA;
        set_in(11'b10101010000, 5'd3, 64'h12, 5'd4, 64'd0, 5'd0, 64'd0, 9'd0);
        tick();
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_hit", data_1, 64'hAA);
`else
        chk("fwd_off", data_1, 64'h12);
`endif
        fwd_rd = 5'd31;
        set_in(11'b10101010000, 5'd31, 64'h55, 5'd4, 64'd0, 5'd0, 64'd0, 9'd0);
        tick();
        chk("fwd_x31_zero", data_1, 64'd0);
        fwd_valid = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [10:0] opc;
            case ($urandom_range(0, 7))
                0: opc = 11'b10001011000;
                1: opc = 11'b11001011000;
                2: opc = 11'b10001010000;
                3: opc = 11'b10101010000;
                4: opc = 11'b11111000010;
                5: opc = 11'b11111000000;
                6: opc = {8'b10110100, 3'($urandom_range(0, 7))};
                default: opc = 11'($urandom);
            endcase
            set_in(opc,
                   ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                   {$urandom, $urandom},
                   ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                   {$urandom, $urandom},
                   ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                   {$urandom, $urandom},
                   9'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            fwd_valid = $urandom_range(0, 1) == 1;
            fwd_rd    = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            fwd_data  = {$urandom, $urandom};
            reset_n   = ($urandom_range(0, 149) != 0);
            tick();
        end

        reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fwd_valid = 1'b0;
        tick(); tick(); tick();
        chk("final_empty", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
